// File: rtl/ktms_afu_rrq_rd_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ktms_afu_rrq_rd_if : doorbell, DMA-get and entry buses of the RRQ reader   |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
interface ktms_afu_rrq_rd_if #(
   parameter int ea_width     = 64,
   parameter int ctxtid_width = 9,
   parameter int tstag_width  = 8,
   parameter int dma_rc_width = 8
);
   logic                     i_db_v;
   logic                     i_db_r;
   logic [0:ctxtid_width-1]  i_db_ctxt;
   logic [0:tstag_width-1]   i_db_tstag;

   logic                     o_get_addr_v;
   logic                     o_get_addr_r;
   logic [0:ea_width]        o_get_addr_ea;
   logic [0:ctxtid_width-1]  o_get_addr_ctxt;
   logic [0:tstag_width-1]   o_get_addr_tstag;

   logic                     i_get_data_v;
   logic                     i_get_data_r;
   logic [0:129]             i_get_data_d;

   logic                     i_get_done_v;
   logic                     i_get_done_r;
   logic [0:dma_rc_width-1]  i_get_done_rc;

   logic                     o_ent_v;
   logic                     o_ent_r;
   logic [0:ctxtid_width-1]  o_ent_ctxt;
   logic [0:63]              o_ent_d;
   logic                     o_ent_empty;
   logic                     o_ent_err;

   modport master (
      input  i_db_v, i_db_ctxt, i_db_tstag, o_get_addr_r, i_get_data_v, i_get_data_d,
             i_get_done_v, i_get_done_rc, o_ent_r,
      output i_db_r, o_get_addr_v, o_get_addr_ea, o_get_addr_ctxt, o_get_addr_tstag,
             i_get_data_r, i_get_done_r, o_ent_v, o_ent_ctxt, o_ent_d, o_ent_empty, o_ent_err
   );

   modport slave (
      output i_db_v, i_db_ctxt, i_db_tstag, o_get_addr_r, i_get_data_v, i_get_data_d,
             i_get_done_v, i_get_done_rc, o_ent_r,
      input  i_db_r, o_get_addr_v, o_get_addr_ea, o_get_addr_ctxt, o_get_addr_tstag,
             i_get_data_r, i_get_done_r, o_ent_v, o_ent_ctxt, o_ent_d, o_ent_empty, o_ent_err
   );
endinterface
`default_nettype wire

// File: rtl/ktms_afu_rrq_rd.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ktms_afu_rrq_rd : per-context toggle-bit response ring reader (DMA get)   |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module ktms_afu_rrq_rd #(
   parameter int ea_width     = 64,
   parameter int ctxtid_width = 9,
   parameter int tstag_width  = 8,
   parameter int dma_rc_width = 8
) (
   input  wire logic                    clk,
   input  wire logic                    reset,
   input  wire logic                    i_st_we,
   input  wire logic                    i_ed_we,
   input  wire logic [0:ctxtid_width-1] i_cfg_ctxt,
   input  wire logic [0:64]             i_cfg_wd,
   ktms_afu_rrq_rd_if.master            bus,
   output logic                         o_perror
);
   localparam int c_idx_w = ctxtid_width - 1;
   localparam int c_depth = 1 << c_idx_w;

   typedef enum logic [2:0] {
      IDLE = 3'd0, RD = 3'd1, ADDR = 3'd2, DATA = 3'd3, DONE = 3'd4, OUT = 3'd5, UPD = 3'd6
   } state_t;

   state_t r_state, w_state_nxt;

   logic [0:64] r_st_mem  [0:c_depth-1];
   logic [0:64] r_ed_mem  [0:c_depth-1];
   logic [0:64] r_cur_mem [0:c_depth-1];

   logic [0:ctxtid_width-1] r_ctxt;
   logic [0:tstag_width-1]  r_tstag;
   logic [0:62]             r_st, r_ed;
   logic [0:63]             r_cur, r_d;
   logic [0:dma_rc_width-1] r_rc;
   logic                    r_stale, r_perr;

   logic [0:c_idx_w-1] w_idx, w_cfg_idx;
   logic               w_cfg_we, w_db_acc, w_data_acc, w_done_acc;
   logic               w_rc_err, w_empty, w_err, w_valid, w_upd_we, w_wrap, w_perr;
   logic [0:63]        w_nxt, w_ea;
   logic               w_unused;

   assign w_idx      = r_ctxt[0:c_idx_w-1];
   assign w_cfg_idx  = i_cfg_ctxt[0:c_idx_w-1];
   assign w_unused   = i_cfg_ctxt[ctxtid_width-1];
   assign w_cfg_we   = i_st_we | i_ed_we;
   assign w_db_acc   = (r_state == IDLE) & bus.i_db_v;
   assign w_data_acc = (r_state == DATA) & bus.i_get_data_v;
   assign w_done_acc = (r_state == DONE) & bus.i_get_done_v;

   // A restarted ring overrides everything; rc is only meaningful for a live transaction
   assign w_rc_err = |r_rc;
   assign w_err    = ~r_stale & w_rc_err;
   assign w_empty  = r_stale | (~w_rc_err & (r_d[63] != r_cur[63]));
   assign w_valid  = ~w_err & ~w_empty;
   assign w_upd_we = (r_state == UPD) & ~w_cfg_we & w_valid;

   // Toggle lives in bit 63 of cur; the +8 step never touches it
   assign w_wrap = (r_cur[0:62] == r_ed);
   assign w_nxt  = w_wrap ? {r_st, ~r_cur[63]} : r_cur + 64'd8;
   assign w_ea   = {r_cur[0:62], 1'b0};

   // Odd parity throughout: a good word plus its parity bit has an odd number of ones
   assign w_perr = (w_cfg_we & ~(^i_cfg_wd))
                 | (w_db_acc & ~(^bus.i_db_ctxt))
                 | ((r_state == RD) & (~(^r_st_mem[w_idx]) | ~(^r_ed_mem[w_idx]) | ~(^r_cur_mem[w_idx])))
                 | (w_data_acc & (r_cur[60] ? ~(^{bus.i_get_data_d[64:127], bus.i_get_data_d[129]})
                                            : ~(^{bus.i_get_data_d[0:63],  bus.i_get_data_d[128]})));

   always_comb begin
      w_state_nxt           = r_state;
      bus.i_db_r            = 1'b0;
      bus.o_get_addr_v      = 1'b0;
      bus.o_get_addr_ea     = '0;
      bus.o_get_addr_ctxt   = '0;
      bus.o_get_addr_tstag  = '0;
      bus.i_get_data_r      = 1'b0;
      bus.i_get_done_r      = 1'b0;
      bus.o_ent_v           = 1'b0;
      bus.o_ent_ctxt        = '0;
      bus.o_ent_d           = '0;
      bus.o_ent_empty       = 1'b0;
      bus.o_ent_err         = 1'b0;
      case (r_state)
         IDLE: begin
            bus.i_db_r = 1'b1;
            if (bus.i_db_v) w_state_nxt = RD;
         end
         RD: w_state_nxt = ADDR;
         ADDR: begin
            bus.o_get_addr_v     = 1'b1;
            bus.o_get_addr_ea    = {w_ea, ~(^w_ea)};
            bus.o_get_addr_ctxt  = r_ctxt;
            bus.o_get_addr_tstag = r_tstag;
            if (bus.o_get_addr_r) w_state_nxt = DATA;
         end
         DATA: begin
            bus.i_get_data_r = 1'b1;
            if (bus.i_get_data_v) w_state_nxt = DONE;
         end
         DONE: begin
            bus.i_get_done_r = 1'b1;
            if (bus.i_get_done_v) w_state_nxt = OUT;
         end
         OUT: begin
            bus.o_ent_v     = 1'b1;
            bus.o_ent_ctxt  = r_ctxt;
            bus.o_ent_d     = r_d;
            bus.o_ent_empty = w_empty;
            bus.o_ent_err   = w_err;
            if (bus.o_ent_r) w_state_nxt = UPD;
         end
         UPD: begin
            // Config writes own the memory port; retry the pointer update next cycle
            if (!w_cfg_we) w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state  <= IDLE;
         r_ctxt   <= '0;
         r_tstag  <= '0;
         r_st     <= '0;
         r_ed     <= '0;
         r_cur    <= '0;
         r_d      <= '0;
         r_rc     <= '0;
         r_stale  <= 1'b0;
         r_perr   <= 1'b0;
         o_perror <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if (w_db_acc) begin
            r_ctxt  <= bus.i_db_ctxt;
            r_tstag <= bus.i_db_tstag;
            r_stale <= 1'b0;
         end else if (i_st_we && (r_state != IDLE) && (w_cfg_idx == w_idx)) begin
            r_stale <= 1'b1;
         end
         if (r_state == RD) begin
            r_st  <= r_st_mem[w_idx][0:62];
            r_ed  <= r_ed_mem[w_idx][0:62];
            r_cur <= r_cur_mem[w_idx][0:63];
         end
         if (w_data_acc) r_d <= r_cur[60] ? bus.i_get_data_d[64:127] : bus.i_get_data_d[0:63];
         if (w_done_acc) r_rc <= bus.i_get_done_rc;
         r_perr   <= w_perr;
         o_perror <= o_perror | r_perr;
      end
   end

   always_ff @(posedge clk) begin
      if (i_st_we) begin
         r_st_mem[w_cfg_idx]  <= i_cfg_wd;
         r_cur_mem[w_cfg_idx] <= {i_cfg_wd[0:62], 1'b1, ~(^{i_cfg_wd[0:62], 1'b1})};
      end else if (w_upd_we) begin
         r_cur_mem[w_idx] <= {w_nxt, ~(^w_nxt)};
      end
      if (i_ed_we) r_ed_mem[w_cfg_idx] <= i_cfg_wd;
   end
endmodule
`default_nettype wire

// File: tb/tb_ktms_afu_rrq_rd.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_ktms_afu_rrq_rd : scoreboard bench for the RRQ ring reader             |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_ktms_afu_rrq_rd;
   logic        clk;
   logic        reset;
   logic        i_st_we, i_ed_we;
   logic [8:0]  i_cfg_ctxt;
   logic [64:0] i_cfg_wd;
   logic        o_perror;

   ktms_afu_rrq_rd_if bus ();

   ktms_afu_rrq_rd dut (
      .clk        (clk),
      .reset      (reset),
      .i_st_we    (i_st_we),
      .i_ed_we    (i_ed_we),
      .i_cfg_ctxt (i_cfg_ctxt),
      .i_cfg_wd   (i_cfg_wd),
      .bus        (bus),
      .o_perror   (o_perror)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [8:0]  ctxt;
      logic [63:0] ea;
      logic [63:0] d;
      logic        empty;
      logic        err;
   } exp_t;

   exp_t        sb[$];
   int          n_checks = 0;
   int          n_errors = 0;
   logic [63:0] host [logic [63:0]];
   logic [63:0] m_st  [256];
   logic [63:0] m_ed  [256];
   logic [63:0] m_cur [256];
   logic        m_tog [256];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [8:0] mk_ctxt(input logic [7:0] idx);
      return {idx, ~(^idx)};
   endfunction

   function automatic logic [63:0] host_rd(input logic [63:0] a);
      if (host.exists(a)) return host[a];
      return 64'h0;
   endfunction

   task automatic cfg_write(input bit st, input logic [7:0] idx, input logic [63:0] a);
      i_st_we    = st;
      i_ed_we    = !st;
      i_cfg_ctxt = mk_ctxt(idx);
      i_cfg_wd   = {a, ~(^a)};
      tick();
      i_st_we = 1'b0;
      i_ed_we = 1'b0;
      if (st) begin
         m_st[idx]  = a;
         m_cur[idx] = a;
         m_tog[idx] = 1'b1;
      end else begin
         m_ed[idx] = a;
      end
   endtask

   // One full transaction; stale_st injects a ring restart during DATA, cfg_upd a config write during UPD
   task automatic run_txn(input string name, input logic [7:0] idx, input logic [7:0] tag,
                          input logic [7:0] rc, input bit stale_st, input logic [63:0] new_st,
                          input bit cfg_upd);
      exp_t        e, got;
      logic [63:0] line, h0, h1;
      int          n;
      e.ctxt  = mk_ctxt(idx);
      e.ea    = m_cur[idx];
      line    = m_cur[idx] & ~64'hF;
      h0      = host_rd(line);
      h1      = host_rd(line + 64'd8);
      e.d     = m_cur[idx][3] ? h1 : h0;
      e.empty = 1'b0;
      e.err   = 1'b0;
      if (stale_st) e.empty = 1'b1;
      else if (rc != 8'd0) e.err = 1'b1;
      else if (e.d[0] != m_tog[idx]) e.empty = 1'b1;
      else if (m_cur[idx] == m_ed[idx]) begin
         m_cur[idx] = m_st[idx];
         m_tog[idx] = ~m_tog[idx];
      end else begin
         m_cur[idx] = m_cur[idx] + 64'd8;
      end
      sb.push_back(e);

      n_checks++;
      if (bus.i_db_r !== 1'b1) begin
         n_errors++;
         $display("FAIL %s db_ready: got %b want 1", name, bus.i_db_r);
      end
      bus.i_db_v     = 1'b1;
      bus.i_db_ctxt  = e.ctxt;
      bus.i_db_tstag = tag;
      tick();
      bus.i_db_v = 1'b0;

      n = 0;
      while (bus.o_get_addr_v !== 1'b1 && n < 20) begin tick(); n++; end
      n_checks++;
      if (n != 1) begin
         n_errors++;
         $display("FAIL %s addr_latency: got %0d want 1 extra cycle", name, n);
      end
      n_checks++;
      if (bus.o_get_addr_ea !== {e.ea, ~(^e.ea)}) begin
         n_errors++;
         $display("FAIL %s addr_ea: got %h want %h", name, bus.o_get_addr_ea, {e.ea, ~(^e.ea)});
      end
      n_checks++;
      if (bus.o_get_addr_ctxt !== e.ctxt || bus.o_get_addr_tstag !== tag) begin
         n_errors++;
         $display("FAIL %s addr_ctxt_tag: got %h/%h want %h/%h", name,
                  bus.o_get_addr_ctxt, bus.o_get_addr_tstag, e.ctxt, tag);
      end
      bus.o_get_addr_r = 1'b1;
      tick();
      bus.o_get_addr_r = 1'b0;

      bus.i_get_data_v = 1'b1;
      bus.i_get_data_d = {h0, h1, ~(^h0), ~(^h1)};
      if (stale_st) begin
         i_st_we    = 1'b1;
         i_cfg_ctxt = mk_ctxt(idx);
         i_cfg_wd   = {new_st, ~(^new_st)};
      end
      tick();
      bus.i_get_data_v = 1'b0;
      if (stale_st) begin
         i_st_we    = 1'b0;
         m_st[idx]  = new_st;
         m_cur[idx] = new_st;
         m_tog[idx] = 1'b1;
      end

      bus.i_get_done_v  = 1'b1;
      bus.i_get_done_rc = rc;
      tick();
      bus.i_get_done_v = 1'b0;

      n = 0;
      while (bus.o_ent_v !== 1'b1 && n < 20) begin tick(); n++; end
      n_checks++;
      if (n != 0) begin
         n_errors++;
         $display("FAIL %s ent_latency: got %0d want 0 extra cycles", name, n);
      end
      n_checks++;
      if (sb.size() == 0) begin
         n_errors++;
         $display("FAIL %s scoreboard: got empty queue want one entry", name);
      end else begin
         got = sb.pop_front();
         if (bus.o_ent_d !== got.d || bus.o_ent_empty !== got.empty ||
             bus.o_ent_err !== got.err || bus.o_ent_ctxt !== got.ctxt) begin
            n_errors++;
            $display("FAIL %s entry: got d=%h empty=%b err=%b ctxt=%h want d=%h empty=%b err=%b ctxt=%h",
                     name, bus.o_ent_d, bus.o_ent_empty, bus.o_ent_err, bus.o_ent_ctxt,
                     got.d, got.empty, got.err, got.ctxt);
         end
      end
      bus.o_ent_r = 1'b1;
      tick();
      bus.o_ent_r = 1'b0;

      n = 0;
      while (bus.i_db_r !== 1'b1 && n < 20) begin
         if (cfg_upd && n == 0) begin
            i_ed_we    = 1'b1;
            i_cfg_ctxt = mk_ctxt(8'd7);
            i_cfg_wd   = {64'h7000, ~(^64'h7000)};
         end
         tick();
         i_ed_we = 1'b0;
         n++;
      end
      n_checks++;
      if (n != (cfg_upd ? 2 : 1)) begin
         n_errors++;
         $display("FAIL %s db_ready_latency: got %0d want %0d", name, n, cfg_upd ? 2 : 1);
      end
   endtask

   task automatic test_reset();
      reset             = 1'b0;
      i_st_we           = 1'b0;
      i_ed_we           = 1'b0;
      i_cfg_ctxt        = '0;
      i_cfg_wd          = '0;
      bus.i_db_v        = 1'b0;
      bus.i_db_ctxt     = '0;
      bus.i_db_tstag    = '0;
      bus.o_get_addr_r  = 1'b0;
      bus.i_get_data_v  = 1'b0;
      bus.i_get_data_d  = '0;
      bus.i_get_done_v  = 1'b0;
      bus.i_get_done_rc = '0;
      bus.o_ent_r       = 1'b0;
      repeat (3) tick();
      n_checks++;
      if (bus.i_db_r !== 1'b1 || bus.o_get_addr_v !== 1'b0 || bus.o_ent_v !== 1'b0) begin
         n_errors++;
         $display("FAIL reset_handshake: got db_r=%b addr_v=%b ent_v=%b want 1/0/0",
                  bus.i_db_r, bus.o_get_addr_v, bus.o_ent_v);
      end
      reset = 1'b1;
      tick();
      n_checks++;
      if (bus.i_get_data_r !== 1'b0 || bus.i_get_done_r !== 1'b0 || o_perror !== 1'b0) begin
         n_errors++;
         $display("FAIL reset_ready_perror: got data_r=%b done_r=%b perror=%b want 0/0/0",
                  bus.i_get_data_r, bus.i_get_done_r, o_perror);
      end
      n_checks++;
      if (bus.o_get_addr_ea !== '0 || bus.o_ent_d !== '0) begin
         n_errors++;
         $display("FAIL reset_data: got ea=%h ent_d=%h want 0/0", bus.o_get_addr_ea, bus.o_ent_d);
      end
   endtask

   task automatic test_valid_entry();
      cfg_write(1'b1, 8'd5, 64'h1000);
      cfg_write(1'b0, 8'd5, 64'h1010);
      host[64'h1000] = 64'hAB00_0000_0000_0001;
      host[64'h1008] = 64'hCD00_0000_0000_0003;
      host[64'h1010] = 64'hEF00_0000_0000_0005;
      run_txn("valid", 8'd5, 8'h11, 8'h00, 1'b0, 64'h0, 1'b0);
   endtask

   task automatic test_upper_half();
      run_txn("upper", 8'd5, 8'h12, 8'h00, 1'b0, 64'h0, 1'b0);
   endtask

   task automatic test_error();
      run_txn("error", 8'd5, 8'h13, 8'h05, 1'b0, 64'h0, 1'b0);
   endtask

   task automatic test_wrap();
      run_txn("wrap", 8'd5, 8'h14, 8'h00, 1'b0, 64'h0, 1'b0);
      run_txn("wrap_empty", 8'd5, 8'h15, 8'h00, 1'b0, 64'h0, 1'b0);
   endtask

   task automatic test_precedence();
      host[64'h1000] = 64'h1234_0000_0000_0000;
      run_txn("precedence", 8'd5, 8'h16, 8'h00, 1'b0, 64'h0, 1'b1);
   endtask

   task automatic test_back_to_back();
      cfg_write(1'b1, 8'd2, 64'h3000);
      cfg_write(1'b0, 8'd2, 64'h3008);
      host[64'h3000] = 64'h3300_0000_0000_0001;
      host[64'h3008] = 64'h3800_0000_0000_0001;
      run_txn("b2b_c2_a", 8'd2, 8'h21, 8'h00, 1'b0, 64'h0, 1'b0);
      run_txn("b2b_c5",   8'd5, 8'h22, 8'h00, 1'b0, 64'h0, 1'b0);
      run_txn("b2b_c2_b", 8'd2, 8'h23, 8'h00, 1'b0, 64'h0, 1'b0);
      run_txn("b2b_c2_c", 8'd2, 8'h24, 8'h00, 1'b0, 64'h0, 1'b0);
   endtask

   task automatic test_stale();
      host[64'h2000] = 64'h5500_0000_0000_0001;
      host[64'h2008] = 64'h6600_0000_0000_0001;
      run_txn("stale", 8'd5, 8'h31, 8'h00, 1'b1, 64'h2000, 1'b0);
      run_txn("after_stale", 8'd5, 8'h32, 8'h00, 1'b0, 64'h0, 1'b0);
   endtask

   task automatic test_parity();
      n_checks++;
      if (o_perror !== 1'b0) begin
         n_errors++;
         $display("FAIL perror_clean: got %b want 0", o_perror);
      end
      i_ed_we    = 1'b1;
      i_cfg_ctxt = mk_ctxt(8'd9);
      i_cfg_wd   = {64'h9000, ^64'h9000};
      tick();
      i_ed_we = 1'b0;
      n_checks++;
      if (o_perror !== 1'b0) begin
         n_errors++;
         $display("FAIL perror_early: got %b want 0", o_perror);
      end
      tick();
      n_checks++;
      if (o_perror !== 1'b1) begin
         n_errors++;
         $display("FAIL perror_set: got %b want 1", o_perror);
      end
      repeat (3) tick();
      n_checks++;
      if (o_perror !== 1'b1) begin
         n_errors++;
         $display("FAIL perror_sticky: got %b want 1", o_perror);
      end
   endtask

   task automatic test_reset_mid();
      logic [63:0] a, line, h0, h1;
      int          n;
      a    = m_cur[5];
      line = a & ~64'hF;
      h0   = host_rd(line);
      h1   = host_rd(line + 64'd8);
      bus.i_db_v     = 1'b1;
      bus.i_db_ctxt  = mk_ctxt(8'd5);
      bus.i_db_tstag = 8'h41;
      tick();
      bus.i_db_v = 1'b0;
      n = 0;
      while (bus.o_get_addr_v !== 1'b1 && n < 20) begin tick(); n++; end
      bus.o_get_addr_r = 1'b1;
      tick();
      bus.o_get_addr_r = 1'b0;
      bus.i_get_data_v = 1'b1;
      bus.i_get_data_d = {h0, h1, ~(^h0), ~(^h1)};
      tick();
      bus.i_get_data_v = 1'b0;
      n_checks++;
      if (bus.i_get_done_r !== 1'b1) begin
         n_errors++;
         $display("FAIL rst_mid_in_done: got done_r=%b want 1", bus.i_get_done_r);
      end
      reset = 1'b0;
      #1;
      n_checks++;
      if (bus.i_db_r !== 1'b1 || bus.i_get_done_r !== 1'b0 || bus.o_ent_v !== 1'b0 ||
          o_perror !== 1'b0 || bus.o_get_addr_ea !== '0) begin
         n_errors++;
         $display("FAIL rst_mid_outputs: got db_r=%b done_r=%b ent_v=%b perror=%b ea=%h want 1/0/0/0/0",
                  bus.i_db_r, bus.i_get_done_r, bus.o_ent_v, o_perror, bus.o_get_addr_ea);
      end
      tick();
      tick();
      reset = 1'b1;
      tick();
      run_txn("after_reset", 8'd5, 8'h42, 8'h00, 1'b0, 64'h0, 1'b0);
   endtask

   initial begin
      test_reset();
      test_valid_entry();
      test_upper_half();
      test_error();
      test_wrap();
      test_precedence();
      test_back_to_back();
      test_stale();
      test_parity();
      test_reset_mid();
      n_checks++;
      if (sb.size() != 0) begin
         n_errors++;
         $display("FAIL scoreboard_drain: got %0d left want 0", sb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "timeout");
   end
endmodule
`default_nettype wire

// File: doc/ktms_afu_rrq_rd.md
# ktms_afu_rrq_rd

Host-ring consumer for the toggle-bit response-queue format: per context it holds a ring start, end and current pointer, and on a doorbell fetches one 8-byte entry from host memory via a DMA get. It returns the entry only if its toggle bit matches the expected phase, then advances the pointer. At the end of the ring it wraps to start and flips the expected toggle. It sits between the MMIO/context-register path and the DMA get engine, and is the reading end of the ring format produced by the RRQ writer.

## Interface
Parameters:
- ea_width, 64, effective address width excluding parity
- ctxtid_width, 9, context id width including trailing parity bit
- tstag_width, 8, DMA tag width
- dma_rc_width, 8, DMA return code width

Ports:
- clk  in  1  clock; all state is on the rising edge
- reset  in  1  asynchronous, active-low reset
- i_st_we  in  1  write ring start for i_cfg_ctxt; also sets cur=start and toggle=1
- i_ed_we  in  1  write ring end for i_cfg_ctxt
- i_cfg_ctxt  in  ctxtid_width  config context
- i_cfg_wd  in  65  config address [0:63] plus parity [64]
- i_db_v / i_db_r  in/out  1  doorbell handshake
- i_db_ctxt  in  ctxtid_width  doorbell context
- i_db_tstag  in  tstag_width  tag forwarded to the get
- o_get_addr_v / o_get_addr_r  out/in  1  get request handshake
- o_get_addr_ea  out  ea_width+1  entry address plus parity
- o_get_addr_ctxt  out  ctxtid_width  request context
- o_get_addr_tstag  out  tstag_width  request tag
- i_get_data_v / i_get_data_r  in/out  1  single data beat
- i_get_data_d  in  130  two 64-bit halves plus two parity bits
- i_get_done_v / i_get_done_r  in/out  1  completion handshake
- i_get_done_rc  in  dma_rc_width  completion code; 0 = ok
- o_ent_v / o_ent_r  out/in  1  entry handshake
- o_ent_ctxt  out  ctxtid_width  entry context
- o_ent_d  out  64  entry data, toggle bit [63] included
- o_ent_empty  out  1  toggle mismatch or stale; no entry consumed
- o_ent_err  out  1  nonzero rc; no entry consumed
- o_perror  out  1  sticky parity error

## Operation
- Storage: start, end and cur memories, each 65 bits wide and indexed by ctxt[0:ctxtid_width-2]. cur[63] is the expected toggle. Addresses are 8-byte aligned.
- One transaction is in flight at a time. FSM states: IDLE, RD, ADDR, DATA, DONE, OUT, UPD.
- IDLE: i_db_r=1. On i_db_v, capture ctxt and tag, go to RD.
- RD: read start, end and cur memories; go to ADDR.
- ADDR: o_get_addr_v=1, o_get_addr_ea={cur[0:62],1'b0,parity}. On ready, go to DATA.
- DATA: i_get_data_r=1. Capture i_get_data_d[0:63] if cur[60]=0, otherwise [64:127]. Go to DONE.
- DONE: i_get_done_r=1. Capture rc, go to OUT.
- OUT: drive o_ent_*.
  - rc≠0 gives err=1, empty=0.
  - Otherwise, captured d[63]≠cur[63] gives empty=1.
  - Otherwise the entry is valid.
  - On o_ent_r, go to UPD.
- UPD: for a valid entry write nxt to cur, then go to IDLE. Otherwise write nothing.
  - If cur[0:62]==end[0:62], nxt={start[0:62],~cur[63]}.
  - Otherwise nxt=cur+8, with the toggle bit carried.
  - Parity is regenerated on nxt.
- Config precedence: an i_st_we/i_ed_we in the same cycle as UPD takes the memory port first; UPD holds one cycle.
- Stale rule: an i_st_we to the in-flight context after RD marks the transaction stale. OUT then reports empty=1, err=0 and UPD writes nothing.
- Parity uses the capi parity convention. It is checked on i_cfg_wd, i_db_ctxt, memory read data and i_get_data_d for the selected half. Any error sets o_perror, which is cleared only by reset. Data flow is unaffected.

## Timing
- Reset values: all valid/ready outputs 0 except i_db_r=1. o_perror=0, FSM=IDLE. All data outputs 0.
- Memory contents are not reset. A doorbell to an unconfigured context is undefined.
- Doorbell accept to o_get_addr_v: 2 cycles.
- Done accept to o_ent_v: 1 cycle.
- o_ent_r accept to i_db_r: 2 cycles, via UPD.
- Valid outputs hold stable until accepted.
- Reset asserted mid-transaction returns to IDLE immediately; no pointer write occurs.

## Test plan
- Ring setup and valid entry: st=0x1000, ed=0x1010. Host 0x1000 holds 0xAB...01 (toggle 1). Doorbell → get ea=0x1000. Entry emitted with empty=0, err=0. cur becomes 0x1008 with toggle 1.
- Wrap: cur=0x1010 and a valid entry. Doorbell → cur becomes 0x1000 with toggle 0. Next entry with toggle 1 → empty=1 and cur unchanged.
- Upper-half select: cur=0x1008, data in bits [64:127] → o_ent_d equals the upper half.
- Error: rc=0x05 → err=1, cur unchanged. o_dbg-free path is unaffected.
- Stale and precedence:
  - i_st_we to the active context during DATA → empty=1; cur equals the new start with toggle 1.
  - A cfg write coincident with UPD → UPD completes one cycle later.
- Parity and reset:
  - Flipped i_cfg_wd[64] → o_perror=1 two cycles later and held.
  - Reset low during DONE → all outputs return to their reset values and cur is unchanged.
